hififo_fpc_checker: RTL and testbench

- Sink and checker for the from-PC (fpc) FIFO stream of hififo_pcie; the receive-side counterpart of the to-PC counting-pattern generator.
- Drains fpc words, verifies a +1 incrementing 64-bit pattern, counts words and errors, and captures the first mismatch.
- Controlled by PIO writes; status is exposed as registered outputs for LEDs and PIO readback.

---
 rtl/hififo_pkg.sv | 25 ++
 rtl/hififo_lfsr16.sv | 29 ++
 rtl/hififo_fpc_checker.sv | 177 +++++++++++++++++
 tb/tb_hififo_fpc_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hififo_pkg.sv
// Shared encodings for the hififo from-PC stream checker.
package hififo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } fpc_state_e;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_CLR_BIT      = 1;
    localparam int CTRL_AUTOSEED_BIT = 2;
    localparam int CTRL_HALT_BIT     = 3;

    localparam logic [12:0] DEF_CTRL_ADDR = 13'd16;
    localparam logic [12:0] DEF_SEED_ADDR = 13'd17;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic reads_fifo(fpc_state_e s);
        return (s == ST_SYNC) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/hififo_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a read-stall strobe.
module hififo_lfsr16
    import hififo_pkg::*;
(
    input  logic clock,
    input  logic reset,
    output logic stall_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    always_comb begin
        fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d = {fb, lfsr_q[15:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/hififo_fpc_checker.sv
// Drains the fpc stream and checks a +1 counting pattern.
// FPC_CHECKER_THROTTLE_EN adds LFSR-driven read backpressure.
module hififo_fpc_checker
    import hififo_pkg::*;
#(
    parameter logic [12:0] CTRL_ADDR = DEF_CTRL_ADDR,
    parameter logic [12:0] SEED_ADDR = DEF_SEED_ADDR,
    parameter int          ERR_W     = 32,
    parameter int          CNT_W     = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pio_write_valid,
    input  logic [12:0]      pio_address,
    input  logic [63:0]      pio_write_data,
    input  logic [63:0]      fpc_data,
    input  logic             fpc_valid,
    output logic             fpc_read,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] word_count,
    output logic [ERR_W-1:0] err_count,
    output logic [63:0]      first_err_expected,
    output logic [63:0]      first_err_actual,
    output logic             err_flag
);

    fpc_state_e       state_q, state_d;
    logic             en_q, en_d;
    logic             aseed_q, aseed_d;
    logic             halt_q, halt_d;
    logic             rd_q, rd_d;
    logic [63:0]      exp_q, exp_d;
    logic [63:0]      fexp_q, fexp_d;
    logic [63:0]      fact_q, fact_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [ERR_W-1:0] ecnt_q, ecnt_d;
    logic             eflag_q, eflag_d;

    logic ctrl_wr;
    logic seed_wr;
    logic clr;
    logic xfer;
    logic mismatch;
    logic gate;

    assign ctrl_wr  = pio_write_valid && (pio_address == CTRL_ADDR);
    assign seed_wr  = pio_write_valid && (pio_address == SEED_ADDR);
    assign clr      = ctrl_wr && pio_write_data[CTRL_CLR_BIT];
    assign xfer     = fpc_read && fpc_valid;
    assign mismatch = (fpc_data != exp_q);

    always_comb begin
        en_d    = en_q;
        aseed_d = aseed_q;
        halt_d  = halt_q;
        if (ctrl_wr) begin
            en_d    = pio_write_data[CTRL_EN_BIT];
            aseed_d = pio_write_data[CTRL_AUTOSEED_BIT];
            halt_d  = pio_write_data[CTRL_HALT_BIT];
        end
    end

    // Control writes act on the next-state decision in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en_d) begin
                    state_d = aseed_d ? ST_SYNC : ST_CHECK;
                end
            end
            ST_SYNC: begin
                if (xfer) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (xfer && mismatch && halt_d) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en_d) begin
            state_d = ST_IDLE;
        end
        rd_d = reads_fifo(state_d);
    end

    always_comb begin
        exp_d  = exp_q;
        wcnt_d = wcnt_q;
        ecnt_d = ecnt_q;
        fexp_d = fexp_q;
        fact_d = fact_q;
        if (xfer) begin
            exp_d  = fpc_data + 64'd1;
            wcnt_d = wcnt_q + CNT_W'(1);
            if ((state_q == ST_CHECK) && mismatch) begin
                if (ecnt_q == '0) begin
                    fexp_d = exp_q;
                    fact_d = fpc_data;
                end
                if (ecnt_q != '1) begin
                    ecnt_d = ecnt_q + ERR_W'(1);
                end
            end
        end
        if (seed_wr) begin
            exp_d = pio_write_data;
        end
        if (clr) begin
            wcnt_d = '0;
            ecnt_d = '0;
            fexp_d = '0;
            fact_d = '0;
        end
        eflag_d = clr ? 1'b0 : (eflag_q || (ecnt_d != '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            aseed_q <= 1'b0;
            halt_q  <= 1'b0;
            rd_q    <= 1'b0;
            exp_q   <= '0;
            fexp_q  <= '0;
            fact_q  <= '0;
            wcnt_q  <= '0;
            ecnt_q  <= '0;
            eflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            aseed_q <= aseed_d;
            halt_q  <= halt_d;
            rd_q    <= rd_d;
            exp_q   <= exp_d;
            fexp_q  <= fexp_d;
            fact_q  <= fact_d;
            wcnt_q  <= wcnt_d;
            ecnt_q  <= ecnt_d;
            eflag_q <= eflag_d;
        end
    end

`ifdef FPC_CHECKER_THROTTLE_EN
    logic stall;

    hififo_lfsr16 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .stall_o (stall)
    );

    assign gate = !stall;
`else
    assign gate = 1'b1;
`endif

    // Masking with reset keeps the FIFO from popping during a reset cycle.
    assign fpc_read           = rd_q && gate && !reset;
    assign state              = state_q;
    assign word_count         = wcnt_q;
    assign err_count          = ecnt_q;
    assign first_err_expected = fexp_q;
    assign first_err_actual   = fact_q;
    assign err_flag           = eflag_q;

endmodule

// File: tb/tb_hififo_fpc_checker.sv
// Randomized bench for hififo_fpc_checker with a stream-level reference model.
module tb_hififo_fpc_checker;

    localparam int CNT_W = 48;
    localparam int ERR_W = 32;
    localparam logic [12:0] CA = 13'd16;
    localparam logic [12:0] SA = 13'd17;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             pio_write_valid = 1'b0;
    logic [12:0]      pio_address = '0;
    logic [63:0]      pio_write_data = '0;
    logic [63:0]      fpc_data = '0;
    logic             fpc_valid = 1'b0;
    logic             fpc_read;
    logic [1:0]       state;
    logic [CNT_W-1:0] word_count;
    logic [ERR_W-1:0] err_count;
    logic [63:0]      first_err_expected;
    logic [63:0]      first_err_actual;
    logic             err_flag;

    hififo_fpc_checker dut (
        .clock              (clock),
        .reset              (reset),
        .pio_write_valid    (pio_write_valid),
        .pio_address        (pio_address),
        .pio_write_data     (pio_write_data),
        .fpc_data           (fpc_data),
        .fpc_valid          (fpc_valid),
        .fpc_read           (fpc_read),
        .state              (state),
        .word_count         (word_count),
        .err_count          (err_count),
        .first_err_expected (first_err_expected),
        .first_err_actual   (first_err_actual),
        .err_flag           (err_flag)
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int nfail = 0;
    int vpct = 100;
    int thr_cyc = 0;
    int thr_low = 0;

    logic [63:0] q[$];

    logic [63:0]      m_exp;
    logic [63:0]      m_fexp;
    logic [63:0]      m_fact;
    logic [CNT_W-1:0] m_cnt;
    logic [ERR_W-1:0] m_err;
    bit               m_sync;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void m_clear();
        m_cnt  = '0;
        m_err  = '0;
        m_fexp = '0;
        m_fact = '0;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_exp  = '0;
        m_sync = 1'b0;
    endfunction

    function automatic void m_word(input logic [63:0] w);
        m_cnt = m_cnt + 1'b1;
        if (m_sync) begin
            m_sync = 1'b0;
        end else if (w != m_exp) begin
            if (m_err == 0) begin
                m_fexp = m_exp;
                m_fact = w;
            end
            if (m_err != '1) m_err = m_err + 1'b1;
        end
        m_exp = w + 64'd1;
    endfunction

    task automatic step();
        bit xf;
        if (q.size() > 0 && $urandom_range(99) < vpct) begin
            fpc_valid = 1'b1;
            fpc_data  = q[0];
        end else begin
            fpc_valid = 1'b0;
            fpc_data  = {$urandom, $urandom};
        end
        #1;
        xf = fpc_read && fpc_valid;
        if (state == 2'd2) begin
            thr_cyc++;
            if (!fpc_read) thr_low++;
        end
        @(posedge clock);
        if (reset) begin
            m_reset();
        end else begin
            if (xf) m_word(q.pop_front());
            if (pio_write_valid && pio_address == SA) m_exp = pio_write_data;
            if (pio_write_valid && pio_address == CA && pio_write_data[1])
                m_clear();
        end
        @(negedge clock);
        pio_write_valid = 1'b0;
    endtask

    task automatic pio(input logic [12:0] a, input logic [63:0] d);
        pio_write_valid = 1'b1;
        pio_address     = a;
        pio_write_data  = d;
        step();
    endtask

    task automatic run_until(input int keep, input int budget);
        int n = 0;
        while (q.size() > keep && n < budget) begin
            step();
            n++;
        end
        chk("drain", 64'(q.size()), 64'(keep));
    endtask

    task automatic chk_all(input string t);
        chk({t, "/wc"}, 64'(word_count), 64'(m_cnt));
        chk({t, "/ec"}, 64'(err_count), 64'(m_err));
        chk({t, "/fexp"}, first_err_expected, m_fexp);
        chk({t, "/fact"}, first_err_actual, m_fact);
        chk({t, "/flag"}, 64'(err_flag), 64'(m_err != 0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s;
        logic [63:0] nxt;
        int          sz;
        m_reset();
        @(negedge clock);
        step();
        step();
        chk("rst/state", 64'(state), 64'd0);
        chk("rst/rd", 64'(fpc_read), 64'd0);
        chk_all("rst");
        chk("rst/ec0", 64'(err_count), 64'd0);
        reset = 1'b0;

        pio(SA, 64'd100);
        pio(CA, 64'h1);
        chk("s1/state0", 64'(state), 64'd2);
        for (int i = 0; i < 1000; i++) q.push_back(64'd100 + 64'(i));
        run_until(0, 2000);
        chk_all("s1");
        chk("s1/wc1000", 64'(word_count), 64'd1000);
        chk("s1/state", 64'(state), 64'd2);
        pio(CA, 64'h2);
        chk("s1/idle", 64'(state), 64'd0);
        chk_all("s1clr");

        m_sync = 1'b1;
        pio(CA, 64'h5);
        chk("s2/sync", 64'(state), 64'd1);
        q.push_back(64'd5000);
        q.push_back(64'd5001);
        q.push_back(64'd5003);
        q.push_back(64'd5004);
        run_until(0, 50);
        chk_all("s2");
        chk("s2/fexp", first_err_expected, 64'd5002);
        chk("s2/fact", first_err_actual, 64'd5003);
        chk("s2/ec", 64'(err_count), 64'd1);
        chk("s2/wc", 64'(word_count), 64'd4);
        pio(CA, 64'h2);

        pio(SA, 64'hFFFF_FFFF_FFFF_FFFE);
        pio(CA, 64'h1);
        q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        q.push_back(64'd0);
        q.push_back(64'd1);
        run_until(0, 50);
        chk_all("s3");
        chk("s3/ec", 64'(err_count), 64'd0);
        pio(CA, 64'h2);

        pio(SA, 64'd1);
        pio(CA, 64'h9);
        q.push_back(64'd1);
        q.push_back(64'd2);
        q.push_back(64'd9);
        q.push_back(64'd10);
        run_until(1, 50);
        chk("s4/halt", 64'(state), 64'd3);
        chk("s4/rd", 64'(fpc_read), 64'd0);
        for (int i = 0; i < 5; i++) step();
        chk("s4/kept", 64'(q.size()), 64'd1);
        chk("s4/halt2", 64'(state), 64'd3);
        chk_all("s4");
        pio(CA, 64'h2);
        chk("s4/idle", 64'(state), 64'd0);
        chk_all("s4clr");
        chk("s4/wc0", 64'(word_count), 64'd0);
        q.delete();

        vpct = 50;
        s = {$urandom, $urandom};
        pio(SA, s);
        pio(CA, 64'h1);
        for (int i = 0; i < 300; i++) q.push_back(s + 64'(i));
        nxt = s + 64'd300;
        run_until(200, 2000);
        pio(CA, 64'h0);
        chk("s5/off", 64'(state), 64'd0);
        for (int i = 0; i < 6; i++) step();
        chk_all("s5off");
        pio(CA, 64'h1);
        run_until(100, 2000);
        pio(CA, 64'h3);
        run_until(0, 2000);
        chk_all("s5");
        chk("s5/ec", 64'(err_count), 64'd0);

        vpct = 100;
        for (int i = 0; i < 10; i++) q.push_back(nxt + 64'(i));
        pio(SA, 64'd5);
        run_until(0, 50);
        chk_all("s5seed");
        chk("s5seed/ec", 64'(err_count), 64'd1);
        chk("s5seed/fexp", first_err_expected, 64'd5);

        for (int i = 0; i < 20; i++) q.push_back(nxt + 64'd10 + 64'(i));
        for (int i = 0; i < 5; i++) step();
        sz = q.size();
        reset = 1'b1;
        #1;
        chk("s6/rdrst", 64'(fpc_read), 64'd0);
        step();
        chk("s6/sz", 64'(q.size()), 64'(sz));
        chk("s6/state", 64'(state), 64'd0);
        chk("s6/rd", 64'(fpc_read), 64'd0);
        chk_all("s6");
        reset = 1'b0;
        q.delete();

`ifdef FPC_CHECKER_THROTTLE_EN
        thr_cyc = 0;
        thr_low = 0;
        pio(SA, 64'd100);
        pio(CA, 64'h1);
        for (int i = 0; i < 1000; i++) q.push_back(64'd100 + 64'(i));
        run_until(0, 4000);
        chk_all("thr");
        chk("thr/ec", 64'(err_count), 64'd0);
        chk("thr/low", 64'(thr_low * 100 > thr_cyc * 15 &&
                            thr_low * 100 < thr_cyc * 35), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
